ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_bridge_pkg.sv | 25 ++
 rtl/ahb_master_arbiter.sv | 109 ++++++++++
 tb/tb_ahb_master_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ahb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bridge_pkg
// Description : Shared HTRANS encodings and arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_bridge_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  typedef enum logic [0:0] {
    GNT0 = 1'b0,
    GNT1 = 1'b1
  } arb_state_t;

  // NONSEQ and SEQ are the only encodings with bit 1 set.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == c_HTRANS_NONSEQ) || (trans == c_HTRANS_SEQ);
  endfunction

endpackage : ahb_bridge_pkg
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_arbiter
// Description : Two-master AHB arbiter with bounded hold and address/data mux.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_arbiter
  import ahb_bridge_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hbusreq0,
  input  logic        hbusreq1,
  input  logic [1:0]  htrans0,
  input  logic [1:0]  htrans1,
  input  logic [31:0] haddr0,
  input  logic [31:0] haddr1,
  input  logic        hwrite0,
  input  logic        hwrite1,
  input  logic [31:0] hwdata0,
  input  logic [31:0] hwdata1,
  input  logic        hreadyin,
  output logic        hgrant0,
  output logic        hgrant1,
  output logic        hmaster,
  output logic        hmaster_data,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  arb_state_t  r_state;
  logic        r_hgrant0;
  logic        r_hgrant1;
  logic        r_hmaster;
  logic        r_hmaster_data;
  logic [CW-1:0] r_hold_cnt;

  logic        w_own_req;
  logic        w_oth_req;
  logic [1:0]  w_own_trans;
  logic        w_active;
  logic [CW:0] w_hold_sum;
  logic        w_limit;
  logic        w_switch;

  always_comb begin
    w_own_req   = (r_state == GNT1) ? hbusreq1 : hbusreq0;
    w_oth_req   = (r_state == GNT1) ? hbusreq0 : hbusreq1;
    w_own_trans = (r_state == GNT1) ? htrans1  : htrans0;
    w_active    = is_active(w_own_trans);
    // One bit wider than the counter so the sum cannot wrap at MAX_HOLD.
    w_hold_sum  = {1'b0, r_hold_cnt} + {{CW{1'b0}}, w_active};
    w_limit     = (w_hold_sum == (CW+1)'(MAX_HOLD));
    w_switch    = w_oth_req &&
                  (!w_own_req || (w_own_trans == c_HTRANS_IDLE) || w_limit);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state        <= GNT0;
      r_hgrant0      <= 1'b1;
      r_hgrant1      <= 1'b0;
      r_hmaster      <= 1'b0;
      r_hmaster_data <= 1'b0;
      r_hold_cnt     <= '0;
    end else if (hreadyin) begin
      r_hmaster_data <= r_hmaster;
      if (w_switch) begin
        r_hold_cnt <= '0;
        case (r_state)
          GNT0: begin
            r_state   <= GNT1;
            r_hgrant0 <= 1'b0;
            r_hgrant1 <= 1'b1;
            r_hmaster <= 1'b1;
          end
          default: begin
            r_state   <= GNT0;
            r_hgrant0 <= 1'b1;
            r_hgrant1 <= 1'b0;
            r_hmaster <= 1'b0;
          end
        endcase
      end else if (w_active && w_oth_req &&
                   (r_hold_cnt < CW'(MAX_HOLD))) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end

  assign hgrant0      = r_hgrant0;
  assign hgrant1      = r_hgrant1;
  assign hmaster      = r_hmaster;
  assign hmaster_data = r_hmaster_data;

  // Address phase follows the address owner, write data lags one accepted phase.
  assign htrans = r_hmaster      ? htrans1 : htrans0;
  assign haddr  = r_hmaster      ? haddr1  : haddr0;
  assign hwrite = r_hmaster      ? hwrite1 : hwrite0;
  assign hwdata = r_hmaster_data ? hwdata1 : hwdata0;

endmodule : ahb_master_arbiter
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_master_arbiter
// Description : Directed self-checking bench for ahb_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_master_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hbusreq0, hbusreq1;
  logic [1:0]  htrans0, htrans1;
  logic [31:0] haddr0, haddr1;
  logic        hwrite0, hwrite1;
  logic [31:0] hwdata0, hwdata1;
  logic        hreadyin;
  logic        hgrant0, hgrant1, hmaster, hmaster_data;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;

  int n_checks = 0;
  int n_errors = 0;

  ahb_master_arbiter #(.MAX_HOLD(4)) u_dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hbusreq0     (hbusreq0),
    .hbusreq1     (hbusreq1),
    .htrans0      (htrans0),
    .htrans1      (htrans1),
    .haddr0       (haddr0),
    .haddr1       (haddr1),
    .hwrite0      (hwrite0),
    .hwrite1      (hwrite1),
    .hwdata0      (hwdata0),
    .hwdata1      (hwdata1),
    .hreadyin     (hreadyin),
    .hgrant0      (hgrant0),
    .hgrant1      (hgrant1),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .htrans       (htrans),
    .haddr        (haddr),
    .hwrite       (hwrite),
    .hwdata       (hwdata)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_owner(input string tag, input logic m);
    check({tag, "_hgrant0"}, {31'b0, hgrant0}, {31'b0, ~m});
    check({tag, "_hgrant1"}, {31'b0, hgrant1}, {31'b0, m});
    check({tag, "_hmaster"}, {31'b0, hmaster}, {31'b0, m});
  endtask

  initial begin
    hresetn  = 1'b0;
    hbusreq0 = 1'b0; hbusreq1 = 1'b0;
    htrans0  = 2'b00; htrans1 = 2'b00;
    haddr0   = 32'h0; haddr1  = 32'h8000_0010;
    hwrite0  = 1'b0; hwrite1  = 1'b0;
    hwdata0  = 32'h0; hwdata1 = 32'h0;
    hreadyin = 1'b1;

    #12;
    check_owner("reset", 1'b0);
    check("reset_hmaster_data", {31'b0, hmaster_data}, 32'h0);
    hresetn = 1'b1;
    tick();

    // Single requester takes the bus on the next ready edge.
    hbusreq1 = 1'b1; htrans1 = 2'b10;
    tick();
    check_owner("m1_only", 1'b1);
    check("m1_only_haddr", haddr, 32'h8000_0010);
    check("m1_only_htrans", {30'b0, htrans}, 32'h2);

    hbusreq1 = 1'b0; hbusreq0 = 1'b1;
    tick();
    check_owner("back_m0", 1'b0);

    // Wait states freeze the handover.
    hbusreq0 = 1'b0; hbusreq1 = 1'b1; hreadyin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_owner($sformatf("stall%0d", i), 1'b0);
    end
    hreadyin = 1'b1;
    tick();
    check_owner("stall_release", 1'b1);

    hbusreq1 = 1'b0; hbusreq0 = 1'b1; htrans0 = 2'b00;
    tick();
    check_owner("back_m0_b", 1'b0);

    // Hold limit: both requesting, M0 streams; 4th accepted phase hands over.
    hbusreq1 = 1'b1; htrans0 = 2'b10; haddr0 = 32'h0; htrans1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_owner($sformatf("hold%0d", i), 1'b0);
      htrans0 = 2'b11;
      haddr0  = haddr0 + 32'h4;
    end
    haddr0 = 32'h0000_0010; hwrite0 = 1'b1;
    tick();
    hwdata0 = 32'hDEAD_BEEF; hwdata1 = 32'h1111_2222;
    #1;
    check_owner("hold_limit", 1'b1);
    check("handover_hmaster_data", {31'b0, hmaster_data}, 32'h0);
    check("handover_hwdata", hwdata, 32'hDEAD_BEEF);
    check("handover_haddr", haddr, 32'h8000_0010);
    tick();
    check_owner("m1_keeps", 1'b1);
    check("m1_data_owner", {31'b0, hmaster_data}, 32'h1);
    check("m1_hwdata", hwdata, 32'h1111_2222);

    // Simultaneous requests: owner keeps the bus; BUSY is neither active nor IDLE.
    hbusreq1 = 1'b0; hwrite0 = 1'b0;
    tick();
    check_owner("to_m0_c", 1'b0);
    hbusreq1 = 1'b1; htrans0 = 2'b10;
    tick(); check_owner("both_a", 1'b0);
    tick(); check_owner("both_b", 1'b0);
    htrans0 = 2'b01;
    tick(); check_owner("both_busy", 1'b0);
    htrans0 = 2'b10;
    tick(); check_owner("both_c", 1'b0);
    htrans0 = 2'b00;
    tick(); check_owner("m0_idle", 1'b1);

    // Parking on the current owner.
    hbusreq0 = 1'b0; hbusreq1 = 1'b0; htrans1 = 2'b00;
    tick(); tick();
    check_owner("park", 1'b1);
    check("park_hmaster_data", {31'b0, hmaster_data}, 32'h1);

    // Asynchronous reset mid-operation.
    hbusreq1 = 1'b1; htrans1 = 2'b10;
    hresetn = 1'b0;
    #1;
    check_owner("async_rst", 1'b0);
    check("async_rst_hmaster_data", {31'b0, hmaster_data}, 32'h0);
    #10;
    hbusreq1 = 1'b0;
    hresetn = 1'b1;
    tick();
    check_owner("post_rst", 1'b0);
    hbusreq1 = 1'b1;
    tick();
    check_owner("post_rst_switch", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_ahb_master_arbiter
`default_nettype wire
